// File: rtl/ext_pipe.sv
// Immediate-extension stage for the decode->execute path.
// Extends in_imm by in_mode and buffers results in a small output FIFO.
module ext_pipe #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [25:0]                in_imm,
  input  logic [2:0]                 in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_err,
  output logic [$clog2(DEPTH):0]     out_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0]     count;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DATA_W:0]   mem [DEPTH];
  logic [DATA_W:0]   head;
  logic [DATA_W-1:0] ext;
  logic              err;
  logic              push;
  logic              pop;

  always_comb begin
    ext = '0;
    err = 1'b0;
    unique case (in_mode)
      3'd0: ext = DATA_W'({48'b0, in_imm[15:0]});
      3'd1: ext = DATA_W'({{48{in_imm[15]}}, in_imm[15:0]});
      3'd2: ext[DATA_W-1 -: 16] = in_imm[15:0];
      3'd3: ext = DATA_W'({59'b0, in_imm[10:6]});
      3'd4: ext = DATA_W'({{46{in_imm[15]}}, in_imm[15:0], 2'b00});
      3'd5: ext = DATA_W'({36'b0, in_imm, 2'b00});
      default: err = 1'b1;
    endcase
  end

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {err, ext};
  end

  assign head      = mem[rd_ptr];
  assign out_data  = out_valid ? head[DATA_W-1:0] : '0;
  assign out_err   = out_valid & head[DATA_W];
  assign out_count = count;

endmodule
